// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add multiplier that borrows the shared combinational ALU, one add per cycle
module alu_mul_seq #(
  parameter int         WIDTH      = 32,
  parameter bit         EARLY_EXIT = 1'b1,
  parameter logic [2:0] ALU_ADD    = 3'b010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_sel,
  output logic [WIDTH-1:0] alu_read1,
  output logic [WIDTH-1:0] alu_read2,
  output logic [2:0]       alu_ops,
  input  logic [WIDTH-1:0] alu_out
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier, r_cnt;
  logic             w_run, w_accept, w_last;
  assign w_run    = r_state == S_RUN;
  assign w_accept = ready && start;
  assign w_last   = (r_cnt == LAST) || (EARLY_EXIT && r_mplier[WIDTH-1:1] == '0);
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  // next state: abort beats completion; ready states accept a new start
  always_comb begin
    w_next = S_IDLE;
    w_next = w_accept ? S_RUN : w_run ? (abort ? S_IDLE : w_last ? S_DONE : S_RUN) : S_IDLE;
  end
  // ALU is driven only while running; outside RUN the mux ignores these
  always_comb begin
    ready     = (r_state == S_IDLE) || (r_state == S_DONE);
    done      = r_state == S_DONE;
    alu_sel   = w_run;
    alu_read1 = w_run ? r_acc : '0;
    alu_read2 = (w_run && r_mplier[0]) ? r_mcand : '0;
    alu_ops   = ALU_ADD;
  end
  // operand capture, one partial-product step per RUN cycle, result on final step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      result   <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= op_a;
      r_mplier <= op_b;
      r_cnt    <= '0;
    end else if (w_run) begin
      r_acc    <= alu_out;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (!abort && w_last) result <= alu_out;
    end
  end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed checks of the multiply sequencer with early exit on and off
module tb_alu_mul_seq;
  localparam logic [2:0] ADD = 3'b010;
  logic        clk = 1'b0, rst_n = 1'b0, abort = 1'b0, start1 = 1'b0, start0 = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        ready1, done1, sel1, ready0, done0, sel0;
  logic [31:0] result1, rd1_1, rd2_1, result0, rd1_0, rd2_0, alu_out1, alu_out0;
  logic [2:0]  ops1, ops0;
  int          n_checks = 0, n_fail = 0;
  assign alu_out1 = rd1_1 + rd2_1;
  assign alu_out0 = rd1_0 + rd2_0;
  always #5 clk = ~clk;
  alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b1), .ALU_ADD(ADD)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .op_a(op_a), .op_b(op_b),
    .ready(ready1), .done(done1), .result(result1), .alu_sel(sel1), .alu_read1(rd1_1),
    .alu_read2(rd2_1), .alu_ops(ops1), .alu_out(alu_out1));
  alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b0), .ALU_ADD(ADD)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .op_a(op_a), .op_b(op_b),
    .ready(ready0), .done(done0), .result(result0), .alu_sel(sel0), .alu_read1(rd1_0),
    .alu_read2(rd2_0), .alu_ops(ops0), .alu_out(alu_out0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(input bit ee0, input int n_exp, input logic [31:0] exp, input string tag);
    int  n = 0;
    bit  seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (ee0 ? done0 : done1) begin
        seen = 1;
        break;
      end
      if (ee0 ? sel0 : sel1) begin
        n++;
        chk({tag, " alu_ops"}, {29'd0, ee0 ? ops0 : ops1}, {29'd0, ADD});
      end
      @(negedge clk);
    end
    chk({tag, " done seen"}, {31'd0, seen}, 32'd1);
    chk({tag, " run cycles"}, n, n_exp);
    chk({tag, " result"}, ee0 ? result0 : result1, exp);
    chk({tag, " ready in done"}, {31'd0, ee0 ? ready0 : ready1}, 32'd1);
  endtask
  task automatic do_op(input bit ee0, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int n_exp, input string tag);
    @(negedge clk);
    op_a = a;
    op_b = b;
    if (ee0) start0 = 1'b1;
    else     start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    wait_done(ee0, n_exp, exp, tag);
  endtask
  initial begin
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("reset ready", {31'd0, ready1}, 32'd1);
    chk("reset done", {31'd0, done1}, 32'd0);
    chk("reset alu_sel", {31'd0, sel1}, 32'd0);
    chk("reset result", result1, 32'd0);
    chk("reset read1", rd1_1, 32'd0);
    chk("reset ops", {29'd0, ops1}, {29'd0, ADD});
    do_op(0, 32'd3, 32'd5, 32'd15, 3, "3x5");
    do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, "ffx ff");
    do_op(0, 32'd9, 32'd0, 32'd0, 1, "9x0");
    do_op(1, 32'd7, 32'd2, 32'd14, 32, "ee0 7x2");
    do_op(0, 32'd3, 32'd5, 32'd15, 3, "b2b first");
    op_a   = 32'd6;
    op_b   = 32'd7;
    start1 = 1'b1;
    @(negedge clk);
    chk("b2b no idle", {31'd0, sel1}, 32'd1);
    op_a = 32'd100;
    op_b = 32'd100;
    chk("busy ready", {31'd0, ready1}, 32'd0);
    @(negedge clk);
    start1 = 1'b0;
    wait_done(0, 2, 32'd42, "b2b 6x7");
    @(negedge clk);
    op_a   = 32'h10;
    op_b   = 32'h8000_0000;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("abort in run", {31'd0, sel1}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort ready", {31'd0, ready1}, 32'd1);
    chk("abort alu_sel", {31'd0, sel1}, 32'd0);
    chk("abort result", result1, 32'd42);
    for (int i = 0; i < 3; i++) begin
      chk("abort no done", {31'd0, done1}, 32'd0);
      @(negedge clk);
    end
    op_a   = 32'hFFFF_FFFF;
    op_b   = 32'hFFFF_FFFF;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre-reset busy", {31'd0, sel1}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ready", {31'd0, ready1}, 32'd1);
    chk("async rst alu_sel", {31'd0, sel1}, 32'd0);
    chk("async rst result", result1, 32'd0);
    chk("async rst done", {31'd0, done1}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst idle", {31'd0, ready1}, 32'd1);
    chk("post-rst no done", {31'd0, done1}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
